trigger_seq_ctrl: RTL and testbench
===================================

# trigger_seq_ctrl

Run-level sequencer for the pulse-train trigger detector. It arms the detector, waits for the final trigger stage, and emits a programmable-width trigger pulse. It also latches the measured time-of-flight into a result register with a valid/ack handshake, then holds off and re-arms for a programmed number of shots or continuously. It sits between the AXI register bank and the detector, in the `rxclk` (125 MHz) domain.

## Interface
- `C_S_AXI_DATA_WIDTH`, 32: width of the config, ToF and result words.
- `SHOT_WIDTH`, 16: width of the shot counters.
- `PW_WIDTH`, 16: width of the pulse-width config.

Ports:
- `rxclk`  in  1  sole clock.
- `rst`  in  1  synchronous, active-high reset.
- `arm_cmd`  in  1  single-cycle start request; honoured only in IDLE.
- `abort_cmd`  in  1  single-cycle stop request; honoured in any state.
- `cfg_shots`  in  SHOT_WIDTH  shots per run; 0 means continuous.
- `cfg_holdoff`  in  C_S_AXI_DATA_WIDTH  cycles between end of pulse and re-arm.
- `cfg_timeout`  in  C_S_AXI_DATA_WIDTH  maximum armed cycles per shot; 0 means no timeout.
- `cfg_pulse_width`  in  PW_WIDTH  trigger pulse width in cycles; 0 is treated as 1.
- `det_pls`  in  8  detector stage flags; bit 4 means the trigger fired.
- `det_tof`  in  C_S_AXI_DATA_WIDTH  detector time-of-flight word.
- `trig_enable`  out  1  detector enable; low resets the detector.
- `trig_out`  out  1  trigger pulse.
- `busy`  out  1  high in every state except IDLE.
- `shot_cnt`  out  SHOT_WIDTH  shots fired in the current run.
- `result_tof`  out  C_S_AXI_DATA_WIDTH  latched ToF.
- `result_shot`  out  SHOT_WIDTH  shot index of the latched ToF, 1-based.
- `result_valid`  out  1  result pending.
- `result_ack`  in  1  consumer acknowledge.
- `timeout_flag`  out  1  sticky; cleared by an accepted arm.
- `overrun_flag`  out  1  sticky; cleared by an accepted arm.

## Operation
- All outputs are registered. On `rst` every output is 0 and the state is IDLE.
- States:
  - **IDLE**: `trig_enable`=0. An `arm_cmd` without `abort_cmd`:
    - latches all `cfg_*` inputs;
    - clears `shot_cnt`, `timeout_flag` and `overrun_flag`;
    - moves to ARMED.
- **ARMED**: `trig_enable`=1 and the armed timer counts up from 0.
  - If `det_pls[4]`=1: latch `det_tof`, increment `shot_cnt`, go to FIRE.
  - Else, if the timeout is non-zero and the timer equals it: set `timeout_flag`, go to IDLE.
  - Detection beats timeout when both occur in the same cycle.
- **FIRE**: `trig_out`=1 and `trig_enable`=0 for exactly W cycles, where W = max(`cfg_pulse_width`,1).
  - Then, if `cfg_shots`≠0 and `shot_cnt`==`cfg_shots`, go to IDLE.
  - Otherwise go to HOLDOFF.
- **HOLDOFF**: `trig_enable`=0 for `cfg_holdoff` cycles. Zero cycles means the block goes straight to ARMED.
  - `trig_enable` is therefore low for at least W ≥ 1 cycles between shots, which clears the detector's stage flags.
- `abort_cmd` in any state gives IDLE on the next cycle, with `trig_out`=0 and `trig_enable`=0.
  - Result registers and sticky flags are untouched.
  - `abort_cmd` and `arm_cmd` together in IDLE: abort wins.
- `arm_cmd` while busy is ignored.
- Result handshake:
  - A latch sets `result_valid`. `result_ack` while valid clears it on the next cycle.
  - If a new latch arrives while valid and no ack is present in the same cycle: overwrite with the newest result and set `overrun_flag`.
  - If ack and a new latch arrive in the same cycle: the new result becomes valid and there is no overrun.
- Continuous mode: `shot_cnt` wraps from 0xFFFF to 0x0000 and the run continues.
- `cfg_*` changes during a run have no effect until the next arm.

## Timing
- `arm_cmd` sampled at cycle 0 gives `busy`=1 and `trig_enable`=1 at cycle 1.
- `det_pls[4]` sampled high at cycle k gives:
  - `trig_out`=1 over cycles k+1 to k+W;
  - `trig_enable`=0 from cycle k+1;
  - `result_valid`, `result_tof` and `result_shot` updated at cycle k+1.
- Re-arm: `trig_enable`=1 at cycle k+1+W+H, where H = `cfg_holdoff`.
- Last shot: `busy`=0 at cycle k+W+1.
- Timeout: entering ARMED at cycle a, with no detection, gives `timeout_flag`=1 and `trig_enable`=0 at cycle a+T+1, where T = `cfg_timeout`.
- `abort_cmd` at cycle j gives `busy`=0 at cycle j+1.

## Test plan
- Single shot:
  - Stimulus: shots=1, W=4, H=10; `det_pls[4]` raised 20 cycles after arm with `det_tof`=0x1234.
  - Required: `trig_out` high for exactly 4 cycles; `result_tof`=0x1234, `result_shot`=1; `busy` falls at k+5; `trig_enable` never re-asserts.
- Three-shot run:
  - Stimulus: shots=3, H=0, W=1.
  - Required: `trig_enable` low exactly 1 cycle between shots; `shot_cnt` goes 1, 2, 3; then IDLE.
- Timeout:
  - Stimulus: T=100, no detection.
  - Required: `timeout_flag`=1 and `busy`=0 at a+101.
  - Stimulus: repeat with detection at timer=100.
  - Required: FIRE is entered and `timeout_flag` stays 0.
- Handshake:
  - Stimulus: two shots with no ack.
  - Required: `overrun_flag`=1; `result_shot`=2.
  - Stimulus: ack coincident with the second latch.
  - Required: `result_valid`=1 and `overrun_flag`=0.
- Abort mid-FIRE with W=50:
  - Required: `trig_out`=0 next cycle; IDLE; `result_valid` preserved.
  - Stimulus: `arm_cmd` and `abort_cmd` together in IDLE.
  - Required: stays IDLE.
- `rst` asserted mid-HOLDOFF:
  - Required: all outputs 0 next cycle; `arm_cmd` pulses while busy are ignored.

Source files
------------

// File: rtl/trigger_seq_ctrl.sv
// -----------------------------------------------------------------------------
// trigger_seq_ctrl
//
// Run-level sequencer for the pulse-train trigger detector (rxclk domain).
// Arms the detector, waits for the final trigger stage, emits a trigger pulse
// of programmable width, and latches the measured time-of-flight into a result
// register guarded by a valid/ack handshake. After each shot it holds off and
// re-arms, either for a programmed number of shots or continuously.
//
// Ports
//   rxclk            sole clock
//   rst              synchronous, active-high reset
//   arm_cmd          single-cycle start request (accepted only when idle)
//   abort_cmd        single-cycle stop request (accepted in any state)
//   cfg_shots        shots per run, 0 = continuous
//   cfg_holdoff      cycles between end of pulse and re-arm
//   cfg_timeout      maximum armed cycles per shot, 0 = no timeout
//   cfg_pulse_width  trigger pulse width in cycles, 0 behaves as 1
//   det_pls          detector stage flags, bit 4 = trigger fired
//   det_tof          detector time-of-flight word
//   trig_enable      detector enable, low holds the detector in reset
//   trig_out         trigger pulse
//   busy             high whenever a run is in progress
//   shot_cnt         shots fired in the current run
//   result_tof       latched time-of-flight
//   result_shot      1-based shot index of the latched time-of-flight
//   result_valid     a result is pending for the consumer
//   result_ack       consumer acknowledge
//   timeout_flag     sticky, an armed window expired without a trigger
//   overrun_flag     sticky, an unacknowledged result was overwritten
// -----------------------------------------------------------------------------
module trigger_seq_ctrl #(
  parameter int C_S_AXI_DATA_WIDTH = 32,
  parameter int SHOT_WIDTH         = 16,
  parameter int PW_WIDTH           = 16
) (
  input  logic                          rxclk,
  input  logic                          rst,
  input  logic                          arm_cmd,
  input  logic                          abort_cmd,
  input  logic [SHOT_WIDTH-1:0]         cfg_shots,
  input  logic [C_S_AXI_DATA_WIDTH-1:0] cfg_holdoff,
  input  logic [C_S_AXI_DATA_WIDTH-1:0] cfg_timeout,
  input  logic [PW_WIDTH-1:0]           cfg_pulse_width,
  input  logic [7:0]                    det_pls,
  input  logic [C_S_AXI_DATA_WIDTH-1:0] det_tof,
  output logic                          trig_enable,
  output logic                          trig_out,
  output logic                          busy,
  output logic [SHOT_WIDTH-1:0]         shot_cnt,
  output logic [C_S_AXI_DATA_WIDTH-1:0] result_tof,
  output logic [SHOT_WIDTH-1:0]         result_shot,
  output logic                          result_valid,
  input  logic                          result_ack,
  output logic                          timeout_flag,
  output logic                          overrun_flag
);

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_ARMED   = 2'd1,
    ST_FIRE    = 2'd2,
    ST_HOLDOFF = 2'd3
  } state_t;

  state_t r_state;
  state_t w_stateNext;

  // Run configuration captured at arm time so that register-bank writes made
  // during a run only take effect on the next arm.
  logic [SHOT_WIDTH-1:0]         r_cfgShots;
  logic [C_S_AXI_DATA_WIDTH-1:0] r_cfgTimeout;
  logic [C_S_AXI_DATA_WIDTH-1:0] r_holdLast;
  logic                          r_holdZero;
  logic [PW_WIDTH-1:0]           r_pwLast;

  // One cycle counter shared by ARMED (timeout timer), FIRE (pulse length)
  // and HOLDOFF (re-arm delay); it restarts at 0 on every state change.
  logic [C_S_AXI_DATA_WIDTH-1:0] r_cnt;

  logic                          w_armAccept;
  logic                          w_latch;
  logic                          w_timeout;
  logic [PW_WIDTH-1:0]           w_pwLastIn;
  logic [C_S_AXI_DATA_WIDTH-1:0] w_holdLastIn;
  logic                          w_holdZeroIn;
  logic                          w_fireDone;
  logic                          w_holdDone;
  logic                          w_lastShot;
  logic                          w_unusedPls;

  // Only the final trigger stage matters to the sequencer.
  assign w_unusedPls = ^{det_pls[7:5], det_pls[3:0]};

  // Terminal counts are precomputed at arm time; a zero pulse width is
  // treated as a one-cycle pulse.
  assign w_pwLastIn   = (cfg_pulse_width == '0) ? '0 : cfg_pulse_width - PW_WIDTH'(1);
  assign w_holdLastIn = cfg_holdoff - C_S_AXI_DATA_WIDTH'(1);
  assign w_holdZeroIn = (cfg_holdoff == '0);

  assign w_fireDone = (r_cnt == C_S_AXI_DATA_WIDTH'(r_pwLast));
  assign w_holdDone = (r_cnt == r_holdLast);
  assign w_lastShot = (r_cfgShots != '0) && (shot_cnt == r_cfgShots);

  // State register.
  always_ff @(posedge rxclk) begin
    if (rst) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_stateNext;
    end
  end

  // Next-state logic and the single-cycle event strobes that drive the
  // datapath. Abort overrides every state, including a coincident arm in IDLE
  // and a coincident detection in ARMED, so an aborted cycle never latches.
  always_comb begin
    w_stateNext = r_state;
    w_armAccept = 1'b0;
    w_latch     = 1'b0;
    w_timeout   = 1'b0;
    if (abort_cmd) begin
      w_stateNext = ST_IDLE;
    end else begin
      case (r_state)
        ST_IDLE: begin
          if (arm_cmd) begin
            w_armAccept = 1'b1;
            w_stateNext = ST_ARMED;
          end
        end
        ST_ARMED: begin
          // Detection takes priority over a timeout in the same cycle.
          if (det_pls[4]) begin
            w_latch     = 1'b1;
            w_stateNext = ST_FIRE;
          end else if ((r_cfgTimeout != '0) && (r_cnt == r_cfgTimeout)) begin
            w_timeout   = 1'b1;
            w_stateNext = ST_IDLE;
          end
        end
        ST_FIRE: begin
          if (w_fireDone) begin
            if (w_lastShot) begin
              w_stateNext = ST_IDLE;
            end else if (r_holdZero) begin
              w_stateNext = ST_ARMED;
            end else begin
              w_stateNext = ST_HOLDOFF;
            end
          end
        end
        ST_HOLDOFF: begin
          if (w_holdDone) begin
            w_stateNext = ST_ARMED;
          end
        end
        default: begin
          w_stateNext = ST_IDLE;
        end
      endcase
    end
  end

  // Shared phase counter: cleared on entry to a new state and held at zero
  // while idle.
  always_ff @(posedge rxclk) begin
    if (rst) begin
      r_cnt <= '0;
    end else if ((w_stateNext != r_state) || (w_stateNext == ST_IDLE)) begin
      r_cnt <= '0;
    end else begin
      r_cnt <= r_cnt + C_S_AXI_DATA_WIDTH'(1);
    end
  end

  // Configuration snapshot taken only when an arm is accepted.
  always_ff @(posedge rxclk) begin
    if (rst) begin
      r_cfgShots   <= '0;
      r_cfgTimeout <= '0;
      r_holdLast   <= '0;
      r_holdZero   <= 1'b1;
      r_pwLast     <= '0;
    end else if (w_armAccept) begin
      r_cfgShots   <= cfg_shots;
      r_cfgTimeout <= cfg_timeout;
      r_holdLast   <= w_holdLastIn;
      r_holdZero   <= w_holdZeroIn;
      r_pwLast     <= w_pwLastIn;
    end
  end

  // Registered control outputs, decoded from the next state so they line up
  // with the state they describe.
  always_ff @(posedge rxclk) begin
    if (rst) begin
      trig_enable <= 1'b0;
      trig_out    <= 1'b0;
      busy        <= 1'b0;
    end else begin
      trig_enable <= (w_stateNext == ST_ARMED);
      trig_out    <= (w_stateNext == ST_FIRE);
      busy        <= (w_stateNext != ST_IDLE);
    end
  end

  // Shot counter: restarted by an accepted arm, stepped on each detection.
  // In continuous mode it simply wraps.
  always_ff @(posedge rxclk) begin
    if (rst) begin
      shot_cnt <= '0;
    end else if (w_armAccept) begin
      shot_cnt <= '0;
    end else if (w_latch) begin
      shot_cnt <= shot_cnt + SHOT_WIDTH'(1);
    end
  end

  // Result register and handshake. A new latch always wins over an ack in
  // the same cycle; it is only an overrun when the pending result was not
  // being acknowledged at that moment.
  always_ff @(posedge rxclk) begin
    if (rst) begin
      result_tof   <= '0;
      result_shot  <= '0;
      result_valid <= 1'b0;
    end else if (w_latch) begin
      result_tof   <= det_tof;
      result_shot  <= shot_cnt + SHOT_WIDTH'(1);
      result_valid <= 1'b1;
    end else if (result_valid && result_ack) begin
      result_valid <= 1'b0;
    end
  end

  // Sticky status flags, cleared only by an accepted arm or reset.
  always_ff @(posedge rxclk) begin
    if (rst) begin
      timeout_flag <= 1'b0;
      overrun_flag <= 1'b0;
    end else if (w_armAccept) begin
      timeout_flag <= 1'b0;
      overrun_flag <= 1'b0;
    end else begin
      if (w_timeout) begin
        timeout_flag <= 1'b1;
      end
      if (w_latch && result_valid && !result_ack) begin
        overrun_flag <= 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_trigger_seq_ctrl.sv
// -----------------------------------------------------------------------------
// tb_trigger_seq_ctrl
//
// Directed scenarios for trigger_seq_ctrl. The stimulus process pushes
// timestamped expectations into a scoreboard queue and expected pulse widths
// into a pulse queue; an independent monitor pops and compares them as the DUT
// reaches each cycle and as each trigger pulse completes.
// -----------------------------------------------------------------------------
module tb_trigger_seq_ctrl;

  localparam int DW = 32;
  localparam int SW = 16;
  localparam int PW = 16;

  localparam int S_TEN    = 0;
  localparam int S_TOUT   = 1;
  localparam int S_BUSY   = 2;
  localparam int S_SHOT   = 3;
  localparam int S_RTOF   = 4;
  localparam int S_RSHOT  = 5;
  localparam int S_RVALID = 6;
  localparam int S_TFLAG  = 7;
  localparam int S_OVR    = 8;

  typedef struct {
    int          cyc;
    int          sel;
    logic [31:0] exp;
    string       name;
  } expItem_t;

  logic          rxclk = 1'b0;
  logic          rst = 1'b1;
  logic          arm_cmd = 1'b0;
  logic          abort_cmd = 1'b0;
  logic [SW-1:0] cfg_shots = '0;
  logic [DW-1:0] cfg_holdoff = '0;
  logic [DW-1:0] cfg_timeout = '0;
  logic [PW-1:0] cfg_pulse_width = '0;
  logic [7:0]    det_pls = '0;
  logic [DW-1:0] det_tof = '0;
  logic          result_ack = 1'b0;
  logic          trig_enable;
  logic          trig_out;
  logic          busy;
  logic [SW-1:0] shot_cnt;
  logic [DW-1:0] result_tof;
  logic [SW-1:0] result_shot;
  logic          result_valid;
  logic          timeout_flag;
  logic          overrun_flag;

  int       cyc = 0;
  int       checks = 0;
  int       errors = 0;
  bit       finishReq = 1'b0;
  expItem_t expQ[$];
  int       pulseQ[$];

  trigger_seq_ctrl #(
    .C_S_AXI_DATA_WIDTH(DW),
    .SHOT_WIDTH(SW),
    .PW_WIDTH(PW)
  ) dut (
    .rxclk(rxclk),
    .rst(rst),
    .arm_cmd(arm_cmd),
    .abort_cmd(abort_cmd),
    .cfg_shots(cfg_shots),
    .cfg_holdoff(cfg_holdoff),
    .cfg_timeout(cfg_timeout),
    .cfg_pulse_width(cfg_pulse_width),
    .det_pls(det_pls),
    .det_tof(det_tof),
    .trig_enable(trig_enable),
    .trig_out(trig_out),
    .busy(busy),
    .shot_cnt(shot_cnt),
    .result_tof(result_tof),
    .result_shot(result_shot),
    .result_valid(result_valid),
    .result_ack(result_ack),
    .timeout_flag(timeout_flag),
    .overrun_flag(overrun_flag)
  );

  always #4 rxclk = ~rxclk;

  // Cycle index: cycle n is the interval after the n-th rising edge.
  always @(posedge rxclk) cyc <= cyc + 1;

  function automatic logic [31:0] getSig(input int sel);
    case (sel)
      S_TEN:    return {31'b0, trig_enable};
      S_TOUT:   return {31'b0, trig_out};
      S_BUSY:   return {31'b0, busy};
      S_SHOT:   return {16'b0, shot_cnt};
      S_RTOF:   return result_tof;
      S_RSHOT:  return {16'b0, result_shot};
      S_RVALID: return {31'b0, result_valid};
      S_TFLAG:  return {31'b0, timeout_flag};
      S_OVR:    return {31'b0, overrun_flag};
      default:  return 32'hDEAD_BEEF;
    endcase
  endfunction

  // Queue an expected output value for a cycle in the future.
  task automatic checkOutput(input int sel, input int delay, input logic [31:0] exp,
                             input string name);
    expItem_t item;
    item.cyc  = cyc + delay;
    item.sel  = sel;
    item.exp  = exp;
    item.name = name;
    expQ.push_back(item);
  endtask

  // Present one cycle of inputs, then return them to their quiet values.
  task automatic applyStimulus(input logic arm, input logic abort, input logic det,
                               input logic ack, input logic [DW-1:0] tof);
    arm_cmd    = arm;
    abort_cmd  = abort;
    det_pls    = det ? 8'h10 : 8'h00;
    det_tof    = tof;
    result_ack = ack;
    @(negedge rxclk);
    arm_cmd    = 1'b0;
    abort_cmd  = 1'b0;
    det_pls    = 8'h00;
    result_ack = 1'b0;
  endtask

  task automatic idle(input int n);
    repeat (n) @(negedge rxclk);
  endtask

  task automatic setCfg(input int shots, input int hold, input int tout, input int pw);
    cfg_shots       = SW'(shots);
    cfg_holdoff     = DW'(hold);
    cfg_timeout     = DW'(tout);
    cfg_pulse_width = PW'(pw);
  endtask

  task automatic expectAllZero(input int delay, input string name);
    for (int s = S_TEN; s <= S_OVR; s++) checkOutput(s, delay, 32'd0, name);
  endtask

  // Monitor: compares scoreboard entries as their cycle arrives, measures
  // every trigger pulse against the pulse queue, and reports the summary.
  initial begin : monitor
    bit prevTout;
    int pulseLen;
    int expLen;
    prevTout = 1'b0;
    pulseLen = 0;
    forever begin
      @(negedge rxclk);
      for (int i = expQ.size() - 1; i >= 0; i--) begin
        if (expQ[i].cyc <= cyc) begin
          checks++;
          if (expQ[i].cyc < cyc) begin
            errors++;
            $display("[TB] FAIL %s: cycle %0d passed unchecked (now %0d)",
                     expQ[i].name, expQ[i].cyc, cyc);
          end else if (getSig(expQ[i].sel) !== expQ[i].exp) begin
            errors++;
            $display("[TB] FAIL %s @cycle %0d: got 0x%0h expected 0x%0h",
                     expQ[i].name, cyc, getSig(expQ[i].sel), expQ[i].exp);
          end
          expQ.delete(i);
        end
      end
      if (trig_out) begin
        pulseLen = prevTout ? pulseLen + 1 : 1;
      end else if (prevTout) begin
        checks++;
        if (pulseQ.size() == 0) begin
          errors++;
          $display("[TB] FAIL pulse_width: unexpected pulse of %0d cycles ending @%0d",
                   pulseLen, cyc);
        end else begin
          expLen = pulseQ.pop_front();
          if (pulseLen != expLen) begin
            errors++;
            $display("[TB] FAIL pulse_width @cycle %0d: got %0d expected %0d",
                     cyc, pulseLen, expLen);
          end
        end
      end
      prevTout = trig_out;
      if (finishReq) begin
        checks++;
        if (expQ.size() != 0) begin
          errors++;
          $display("[TB] FAIL scoreboard_drain: got %0d pending expected 0", expQ.size());
        end
        checks++;
        if (pulseQ.size() != 0) begin
          errors++;
          $display("[TB] FAIL pulse_drain: got %0d missing pulses expected 0", pulseQ.size());
        end
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
      end
    end
  end

  initial begin : stimulus
    int c;
    int a;
    int k;
    int j;

    // Reset state.
    @(negedge rxclk);
    expectAllZero(1, "reset_state");
    idle(2);
    rst = 1'b0;
    idle(2);

    // Single shot: W=4, H=10, detection 20 cycles after arm. The config is
    // scribbled after arm to show the snapshot is what governs the run.
    $display("[TB] single shot");
    setCfg(1, 10, 0, 4);
    c = cyc;
    checkOutput(S_BUSY, 1, 32'd1, "s1_busy_after_arm");
    checkOutput(S_TEN, 1, 32'd1, "s1_enable_after_arm");
    applyStimulus(1'b1, 1'b0, 1'b0, 1'b0, '0);
    cfg_pulse_width = 16'd9;
    cfg_shots       = 16'd0;
    idle(19);
    k = cyc;
    pulseQ.push_back(4);
    checkOutput(S_TOUT, 1, 32'd1, "s1_tout_start");
    checkOutput(S_TEN, 1, 32'd0, "s1_enable_drop");
    checkOutput(S_TOUT, 4, 32'd1, "s1_tout_last");
    checkOutput(S_TOUT, 5, 32'd0, "s1_tout_end");
    checkOutput(S_RVALID, 1, 32'd1, "s1_rvalid");
    checkOutput(S_RTOF, 1, 32'h1234, "s1_rtof");
    checkOutput(S_RSHOT, 1, 32'd1, "s1_rshot");
    checkOutput(S_SHOT, 1, 32'd1, "s1_shot_cnt");
    checkOutput(S_BUSY, 4, 32'd1, "s1_busy_in_fire");
    checkOutput(S_BUSY, 5, 32'd0, "s1_busy_fall");
    checkOutput(S_TEN, 15, 32'd0, "s1_no_rearm");
    checkOutput(S_TEN, 20, 32'd0, "s1_no_rearm_late");
    applyStimulus(1'b0, 1'b0, 1'b1, 1'b0, 32'h1234);
    idle(25);
    checkOutput(S_RVALID, 1, 32'd0, "s1_ack_clears");
    applyStimulus(1'b0, 1'b0, 1'b0, 1'b1, '0);
    idle(2);

    // Three-shot run, H=0, W=1, results never acknowledged.
    $display("[TB] three-shot run");
    setCfg(3, 0, 0, 1);
    applyStimulus(1'b1, 1'b0, 1'b0, 1'b0, '0);
    idle(2);
    k = cyc;
    pulseQ.push_back(1);
    checkOutput(S_TOUT, 1, 32'd1, "s2_shot1_tout");
    checkOutput(S_TEN, 1, 32'd0, "s2_shot1_gap");
    checkOutput(S_TEN, 2, 32'd1, "s2_shot1_rearm");
    checkOutput(S_SHOT, 1, 32'd1, "s2_shot_cnt_1");
    checkOutput(S_OVR, 1, 32'd0, "s2_no_overrun_yet");
    applyStimulus(1'b0, 1'b0, 1'b1, 1'b0, 32'h11);
    idle(2);
    pulseQ.push_back(1);
    checkOutput(S_SHOT, 1, 32'd2, "s2_shot_cnt_2");
    checkOutput(S_RSHOT, 1, 32'd2, "s2_rshot_2");
    checkOutput(S_RTOF, 1, 32'h22, "s2_rtof_2");
    checkOutput(S_OVR, 1, 32'd1, "s2_overrun");
    checkOutput(S_TEN, 1, 32'd0, "s2_shot2_gap");
    checkOutput(S_TEN, 2, 32'd1, "s2_shot2_rearm");
    applyStimulus(1'b0, 1'b0, 1'b1, 1'b0, 32'h22);
    idle(2);
    pulseQ.push_back(1);
    checkOutput(S_SHOT, 1, 32'd3, "s2_shot_cnt_3");
    checkOutput(S_TOUT, 1, 32'd1, "s2_shot3_tout");
    checkOutput(S_TOUT, 2, 32'd0, "s2_shot3_tout_end");
    checkOutput(S_BUSY, 1, 32'd1, "s2_busy_last_fire");
    checkOutput(S_BUSY, 2, 32'd0, "s2_busy_fall");
    checkOutput(S_TEN, 2, 32'd0, "s2_done_enable");
    checkOutput(S_TEN, 4, 32'd0, "s2_no_rearm");
    applyStimulus(1'b0, 1'b0, 1'b1, 1'b0, 32'h33);
    idle(5);
    checkOutput(S_RVALID, 1, 32'd0, "s2_ack_clears");
    checkOutput(S_OVR, 1, 32'd1, "s2_overrun_sticky");
    applyStimulus(1'b0, 1'b0, 1'b0, 1'b1, '0);
    idle(2);

    // Timeout with T=100 and no detection.
    $display("[TB] timeout");
    setCfg(1, 0, 100, 1);
    checkOutput(S_OVR, 1, 32'd0, "s3_arm_clears_overrun");
    checkOutput(S_BUSY, 1, 32'd1, "s3_busy");
    applyStimulus(1'b1, 1'b0, 1'b0, 1'b0, '0);
    a = cyc;
    checkOutput(S_TEN, 100, 32'd1, "s3_enable_at_T");
    checkOutput(S_BUSY, 100, 32'd1, "s3_busy_at_T");
    checkOutput(S_TFLAG, 100, 32'd0, "s3_tflag_before");
    checkOutput(S_TFLAG, 101, 32'd1, "s3_tflag_set");
    checkOutput(S_BUSY, 101, 32'd0, "s3_busy_fall");
    checkOutput(S_TEN, 101, 32'd0, "s3_enable_fall");
    idle(105);

    // Detection in the very cycle the timer reaches T: detection wins.
    $display("[TB] detection at timeout");
    setCfg(1, 0, 100, 2);
    checkOutput(S_TFLAG, 1, 32'd0, "s3b_arm_clears_tflag");
    applyStimulus(1'b1, 1'b0, 1'b0, 1'b0, '0);
    idle(100);
    pulseQ.push_back(2);
    checkOutput(S_TOUT, 1, 32'd1, "s3b_fire");
    checkOutput(S_TFLAG, 1, 32'd0, "s3b_no_tflag");
    checkOutput(S_TFLAG, 3, 32'd0, "s3b_no_tflag_late");
    checkOutput(S_SHOT, 1, 32'd1, "s3b_shot_cnt");
    checkOutput(S_RTOF, 1, 32'd100, "s3b_rtof");
    checkOutput(S_RVALID, 1, 32'd1, "s3b_rvalid");
    checkOutput(S_BUSY, 2, 32'd1, "s3b_busy_in_fire");
    checkOutput(S_BUSY, 3, 32'd0, "s3b_busy_fall");
    applyStimulus(1'b0, 1'b0, 1'b1, 1'b0, 32'd100);
    idle(5);
    checkOutput(S_RVALID, 1, 32'd0, "s3b_ack_clears");
    applyStimulus(1'b0, 1'b0, 1'b0, 1'b1, '0);
    idle(2);

    // Ack coincident with the second latch: valid stays, no overrun.
    $display("[TB] ack coincident with latch");
    setCfg(2, 2, 0, 1);
    applyStimulus(1'b1, 1'b0, 1'b0, 1'b0, '0);
    idle(1);
    pulseQ.push_back(1);
    checkOutput(S_RVALID, 1, 32'd1, "s4_rvalid_1");
    checkOutput(S_RSHOT, 1, 32'd1, "s4_rshot_1");
    checkOutput(S_TEN, 3, 32'd0, "s4_holdoff_low");
    checkOutput(S_TEN, 4, 32'd1, "s4_rearm");
    applyStimulus(1'b0, 1'b0, 1'b1, 1'b0, 32'h41);
    idle(3);
    pulseQ.push_back(1);
    checkOutput(S_RVALID, 1, 32'd1, "s4_rvalid_2");
    checkOutput(S_OVR, 1, 32'd0, "s4_no_overrun");
    checkOutput(S_RSHOT, 1, 32'd2, "s4_rshot_2");
    checkOutput(S_RTOF, 1, 32'h42, "s4_rtof_2");
    checkOutput(S_BUSY, 2, 32'd0, "s4_busy_fall");
    applyStimulus(1'b0, 1'b0, 1'b1, 1'b1, 32'h42);
    idle(4);
    checkOutput(S_RVALID, 1, 32'd0, "s4_ack_clears");
    applyStimulus(1'b0, 1'b0, 1'b0, 1'b1, '0);
    idle(2);

    // Abort eleven cycles into a 50-cycle pulse.
    $display("[TB] abort mid-fire");
    setCfg(1, 0, 0, 50);
    applyStimulus(1'b1, 1'b0, 1'b0, 1'b0, '0);
    idle(2);
    pulseQ.push_back(11);
    checkOutput(S_RVALID, 1, 32'd1, "s5_rvalid");
    checkOutput(S_TOUT, 11, 32'd1, "s5_tout_before_abort");
    applyStimulus(1'b0, 1'b0, 1'b1, 1'b0, 32'hABCD);
    idle(10);
    checkOutput(S_TOUT, 1, 32'd0, "s5_tout_abort");
    checkOutput(S_BUSY, 1, 32'd0, "s5_busy_abort");
    checkOutput(S_TEN, 1, 32'd0, "s5_enable_abort");
    checkOutput(S_RVALID, 1, 32'd1, "s5_rvalid_kept");
    checkOutput(S_RTOF, 1, 32'hABCD, "s5_rtof_kept");
    checkOutput(S_RSHOT, 1, 32'd1, "s5_rshot_kept");
    applyStimulus(1'b0, 1'b1, 1'b0, 1'b0, '0);
    idle(3);
    checkOutput(S_BUSY, 1, 32'd0, "s5_arm_abort_busy");
    checkOutput(S_TEN, 1, 32'd0, "s5_arm_abort_enable");
    checkOutput(S_BUSY, 3, 32'd0, "s5_arm_abort_stays_idle");
    checkOutput(S_SHOT, 1, 32'd1, "s5_arm_abort_shot_kept");
    checkOutput(S_RVALID, 1, 32'd1, "s5_arm_abort_rvalid_kept");
    applyStimulus(1'b1, 1'b1, 1'b0, 1'b0, '0);
    idle(4);

    // Continuous run reset during HOLDOFF; an arm while busy is ignored.
    $display("[TB] reset during holdoff");
    setCfg(0, 20, 0, 2);
    checkOutput(S_SHOT, 1, 32'd0, "s6_arm_clears_shot");
    applyStimulus(1'b1, 1'b0, 1'b0, 1'b0, '0);
    idle(1);
    pulseQ.push_back(2);
    checkOutput(S_SHOT, 1, 32'd1, "s6_shot_cnt");
    applyStimulus(1'b0, 1'b0, 1'b1, 1'b0, 32'h66);
    idle(5);
    checkOutput(S_BUSY, 1, 32'd1, "s6_arm_ignored_busy");
    checkOutput(S_TEN, 1, 32'd0, "s6_arm_ignored_enable");
    checkOutput(S_SHOT, 1, 32'd1, "s6_arm_ignored_shot");
    checkOutput(S_TOUT, 1, 32'd0, "s6_arm_ignored_tout");
    applyStimulus(1'b1, 1'b0, 1'b0, 1'b0, '0);
    idle(3);
    expectAllZero(1, "s6_reset_outputs");
    checkOutput(S_BUSY, 3, 32'd0, "s6_idle_after_reset");
    rst = 1'b1;
    @(negedge rxclk);
    rst = 1'b0;
    idle(5);

    finishReq = 1'b1;
  end

endmodule
